// File: rtl/drc_cam_pwr_seq_pkg.sv
// Shared types and constants for the camera power/clock sequencer.
package drc_cam_pwr_seq_pkg;

  localparam int SEQ_ST_W = 3;

  typedef enum logic [SEQ_ST_W-1:0] {
    ST_OFF    = 3'd0,
    ST_PWRUP  = 3'd1,
    ST_CLKUP  = 3'd2,
    ST_RSTREL = 3'd3,
    ST_READY  = 3'd4,
    ST_STOP   = 3'd5,
    ST_PWRDN  = 3'd6
  } seq_state_e;

  localparam int CAM_CFG_START_BIT = 0;
  localparam int CAM_CFG_PWDN_BIT  = 1;

  localparam int DEF_DVP_CAM_CFG_W = 32;
  localparam int DEF_PWDN_DLY_CYC  = 125000;
  localparam int DEF_XCLK_DLY_CYC  = 1250;
  localparam int DEF_RST_DLY_CYC   = 2500000;
  localparam int DEF_STOP_DLY_CYC  = 64;

  typedef struct packed {
    logic start;
    logic pwdn;
    logic rst_n;
    logic ready;
    logic busy;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RST = '{start: 1'b0, pwdn: 1'b1, rst_n: 1'b0,
                                       ready: 1'b0, busy: 1'b0};

  // Counter must hold the largest delay minus one; one spare bit keeps it unsigned-safe.
  function automatic int dly_ctn_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  function automatic seq_out_t seq_out_decode(input seq_state_e s);
    seq_out_t o;
    o = SEQ_OUT_RST;
    case (s)
      ST_OFF:    o = '{start: 1'b0, pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, busy: 1'b0};
      ST_PWRUP:  o = '{start: 1'b0, pwdn: 1'b0, rst_n: 1'b0, ready: 1'b0, busy: 1'b1};
      ST_CLKUP:  o = '{start: 1'b1, pwdn: 1'b0, rst_n: 1'b0, ready: 1'b0, busy: 1'b1};
      ST_RSTREL: o = '{start: 1'b1, pwdn: 1'b0, rst_n: 1'b1, ready: 1'b0, busy: 1'b1};
      ST_READY:  o = '{start: 1'b1, pwdn: 1'b0, rst_n: 1'b1, ready: 1'b1, busy: 1'b0};
      ST_STOP:   o = '{start: 1'b1, pwdn: 1'b0, rst_n: 1'b0, ready: 1'b0, busy: 1'b1};
      ST_PWRDN:  o = '{start: 1'b0, pwdn: 1'b1, rst_n: 1'b0, ready: 1'b0, busy: 1'b1};
      default:   o = SEQ_OUT_RST;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/drc_cam_pwr_seq_if.sv
// Software-request / XCLK-generator / pad-side signal bundle of the sequencer.
interface drc_cam_pwr_seq_if
  import drc_cam_pwr_seq_pkg::*;
#(
  parameter int DVP_CAM_CFG_W = DEF_DVP_CAM_CFG_W
);
  logic                     pwr_on_req_i;
  logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_i;
  logic [DVP_CAM_CFG_W-1:0] dcr_cam_cfg_o;
  logic                     dvp_rst_n_o;
  logic                     cam_ready_o;
  logic                     cam_busy_o;
  logic [SEQ_ST_W-1:0]      seq_state_o;

  modport master (
    output pwr_on_req_i, dcr_cam_cfg_i,
    input  dcr_cam_cfg_o, dvp_rst_n_o, cam_ready_o, cam_busy_o, seq_state_o
  );

  modport slave (
    input  pwr_on_req_i, dcr_cam_cfg_i,
    output dcr_cam_cfg_o, dvp_rst_n_o, cam_ready_o, cam_busy_o, seq_state_o
  );
endinterface

// File: rtl/drc_cam_pwr_seq_dly_timer.sv
// Loadable down-counter; holds at zero and flags it so the FSM can time each state.
module drc_dly_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/drc_cam_pwr_seq.sv
// Camera power/clock sequencer: orders PWDN release, XCLK start and RESET release
// on power-up, and the reverse on power-down, with programmable gaps between steps.
module drc_cam_pwr_seq
  import drc_cam_pwr_seq_pkg::*;
#(
  parameter int DVP_CAM_CFG_W = DEF_DVP_CAM_CFG_W,
  parameter int PWDN_DLY_CYC  = DEF_PWDN_DLY_CYC,
  parameter int XCLK_DLY_CYC  = DEF_XCLK_DLY_CYC,
  parameter int RST_DLY_CYC   = DEF_RST_DLY_CYC,
  parameter int STOP_DLY_CYC  = DEF_STOP_DLY_CYC
) (
  input  logic              clk,
  input  logic              rst,
  drc_cam_pwr_seq_if.slave  bus
);

  localparam int DLY_CTN_W = dly_ctn_w(PWDN_DLY_CYC, XCLK_DLY_CYC, RST_DLY_CYC, STOP_DLY_CYC);

  localparam logic [DLY_CTN_W-1:0] PWDN_LD = DLY_CTN_W'(PWDN_DLY_CYC - 1);
  localparam logic [DLY_CTN_W-1:0] XCLK_LD = DLY_CTN_W'(XCLK_DLY_CYC - 1);
  localparam logic [DLY_CTN_W-1:0] RST_LD  = DLY_CTN_W'(RST_DLY_CYC - 1);
  localparam logic [DLY_CTN_W-1:0] STOP_LD = DLY_CTN_W'(STOP_DLY_CYC - 1);

  seq_state_e               state_q, state_d;
  seq_out_t                 out_q, out_d;
  logic                     tmr_load;
  logic [DLY_CTN_W-1:0]     tmr_load_val;
  logic                     tmr_zero;
  logic [DVP_CAM_CFG_W-1:0] cam_cfg;

  drc_dly_timer #(
    .CNT_W (DLY_CTN_W)
  ) u_dly_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // A dropped request always wins over expiry of the current delay.
  always_comb begin
    state_d      = state_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_OFF: begin
        if (bus.pwr_on_req_i) begin
          state_d      = ST_PWRUP;
          tmr_load     = 1'b1;
          tmr_load_val = PWDN_LD;
        end
      end
      ST_PWRUP: begin
        if (!bus.pwr_on_req_i) begin
          state_d      = ST_PWRDN;
          tmr_load     = 1'b1;
          tmr_load_val = PWDN_LD;
        end else if (tmr_zero) begin
          state_d      = ST_CLKUP;
          tmr_load     = 1'b1;
          tmr_load_val = XCLK_LD;
        end
      end
      ST_CLKUP: begin
        if (!bus.pwr_on_req_i) begin
          state_d      = ST_STOP;
          tmr_load     = 1'b1;
          tmr_load_val = STOP_LD;
        end else if (tmr_zero) begin
          state_d      = ST_RSTREL;
          tmr_load     = 1'b1;
          tmr_load_val = RST_LD;
        end
      end
      ST_RSTREL: begin
        if (!bus.pwr_on_req_i) begin
          state_d      = ST_STOP;
          tmr_load     = 1'b1;
          tmr_load_val = STOP_LD;
        end else if (tmr_zero) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (!bus.pwr_on_req_i) begin
          state_d      = ST_STOP;
          tmr_load     = 1'b1;
          tmr_load_val = STOP_LD;
        end
      end
      ST_STOP: begin
        if (tmr_zero) begin
          state_d      = ST_PWRDN;
          tmr_load     = 1'b1;
          tmr_load_val = PWDN_LD;
        end
      end
      ST_PWRDN: begin
        if (tmr_zero) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
    out_d = seq_out_decode(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      out_q   <= SEQ_OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    cam_cfg                    = bus.dcr_cam_cfg_i;
    cam_cfg[CAM_CFG_START_BIT] = out_q.start;
    cam_cfg[CAM_CFG_PWDN_BIT]  = out_q.pwdn;
  end

  assign bus.dcr_cam_cfg_o = cam_cfg;
  assign bus.dvp_rst_n_o   = out_q.rst_n;
  assign bus.cam_ready_o   = out_q.ready;
  assign bus.cam_busy_o    = out_q.busy;
  assign bus.seq_state_o   = state_q;

endmodule
